board_io_ctrl: RTL and testbench



---
 rtl/board_io_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_board_io_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/board_io_ctrl.sv
// Board I/O conditioner: button sync/debounce with edge strobes, PLL-lock
// driven core reset sequencing, and LED pulse stretching.
module board_io_ctrl #(
  parameter int unsigned NUM_BTN          = 3,
  parameter int unsigned NUM_LED          = 4,
  parameter int unsigned DEBOUNCE_CYCLES  = 500000,
  parameter int unsigned LOCK_WAIT_CYCLES = 65536,
  parameter int unsigned STRETCH_CYCLES   = 2500000
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               pll_locked_i,
  input  logic [NUM_BTN-1:0] btn_i,
  input  logic [NUM_LED-1:0] led_i,
  output logic               core_reset_o,
  output logic [NUM_BTN-1:0] btn_level_o,
  output logic [NUM_BTN-1:0] btn_rise_o,
  output logic [NUM_BTN-1:0] btn_fall_o,
  output logic [NUM_LED-1:0] led_o
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned LK_W = $clog2(LOCK_WAIT_CYCLES + 1);
  localparam int unsigned ST_W = (STRETCH_CYCLES == 0) ? 1 : $clog2(STRETCH_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LK_W-1:0] LK_LAST = LK_W'(LOCK_WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Two-flop synchronisers for the asynchronous inputs
  logic               lock_meta_q, lock_sync_q;
  logic [NUM_BTN-1:0] btn_meta_q, btn_sync_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      btn_meta_q  <= '0;
      btn_sync_q  <= '0;
    end else begin
      lock_meta_q <= pll_locked_i;
      lock_sync_q <= lock_meta_q;
      btn_meta_q  <= btn_i;
      btn_sync_q  <= btn_meta_q;
    end
  end

  // Reset sequencer
  state_t          state_q, state_d;
  logic [LK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic            core_reset_q, core_reset_d;

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      ST_HOLD: begin
        lock_cnt_d = '0;
        if (lock_sync_q) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!lock_sync_q) begin
          state_d    = ST_HOLD;
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LK_LAST) begin
          state_d    = ST_RUN;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + LK_W'(1);
        end
      end
      ST_RUN: begin
        lock_cnt_d = '0;
        if (!lock_sync_q) state_d = ST_HOLD;
      end
      default: begin
        state_d    = ST_HOLD;
        lock_cnt_d = '0;
      end
    endcase
    core_reset_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_HOLD;
      lock_cnt_q   <= '0;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      core_reset_q <= core_reset_d;
    end
  end

  // Debounce: accept a change after DEBOUNCE_CYCLES consecutive mismatching cycles
  logic [DB_W-1:0]    db_cnt_q [NUM_BTN];
  logic [DB_W-1:0]    db_cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] btn_level_q, btn_level_d;
  logic [NUM_BTN-1:0] btn_rise_q, btn_rise_d;
  logic [NUM_BTN-1:0] btn_fall_q, btn_fall_d;

  always_comb begin
    btn_level_d = btn_level_q;
    btn_rise_d  = '0;
    btn_fall_d  = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (btn_sync_q[i] == btn_level_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        db_cnt_d[i]    = '0;
        btn_level_d[i] = ~btn_level_q[i];
        // Strobes are suppressed while the core is held in reset
        btn_rise_d[i]  = ~btn_level_q[i] & ~core_reset_q;
        btn_fall_d[i]  = btn_level_q[i] & ~core_reset_q;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      btn_level_q <= '0;
      btn_rise_q  <= '0;
      btn_fall_q  <= '0;
      for (int i = 0; i < NUM_BTN; i++) db_cnt_q[i] <= '0;
    end else begin
      btn_level_q <= btn_level_d;
      btn_rise_q  <= btn_rise_d;
      btn_fall_q  <= btn_fall_d;
      for (int i = 0; i < NUM_BTN; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  // LED drive, with optional stretch counters
  logic [NUM_LED-1:0] led_q;

  if (STRETCH_CYCLES == 0) begin : g_led_pass
    always_ff @(posedge clk_i) begin
      if (reset_i) led_q <= '0;
      else         led_q <= led_i;
    end
  end else begin : g_led_stretch
    logic [ST_W-1:0]    st_cnt_q [NUM_LED];
    logic [ST_W-1:0]    st_cnt_d [NUM_LED];
    logic [NUM_LED-1:0] led_d;

    always_comb begin
      led_d = '0;
      for (int i = 0; i < NUM_LED; i++) begin
        st_cnt_d[i] = st_cnt_q[i];
        led_d[i]    = led_i[i] | (st_cnt_q[i] != '0);
        if (led_i[i])                st_cnt_d[i] = ST_W'(STRETCH_CYCLES);
        else if (st_cnt_q[i] != '0)  st_cnt_d[i] = st_cnt_q[i] - ST_W'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        led_q <= '0;
        for (int i = 0; i < NUM_LED; i++) st_cnt_q[i] <= '0;
      end else begin
        led_q <= led_d;
        for (int i = 0; i < NUM_LED; i++) st_cnt_q[i] <= st_cnt_d[i];
      end
    end
  end

  assign core_reset_o = core_reset_q;
  assign btn_level_o  = btn_level_q;
  assign btn_rise_o   = btn_rise_q;
  assign btn_fall_o   = btn_fall_q;
  assign led_o        = led_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed bench for board_io_ctrl with small debounce/lock/stretch settings.
module tb_board_io_ctrl;

  localparam int unsigned NB = 3;
  localparam int unsigned NL = 4;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          pll_locked_i;
  logic [NB-1:0] btn_i;
  logic [NL-1:0] led_i;
  logic          core_reset_o;
  logic [NB-1:0] btn_level_o, btn_rise_o, btn_fall_o;
  logic [NL-1:0] led_o;

  int errors = 0;
  int checks = 0;
  int rise_cnt;

  board_io_ctrl #(
    .NUM_BTN(NB), .NUM_LED(NL), .DEBOUNCE_CYCLES(4),
    .LOCK_WAIT_CYCLES(8), .STRETCH_CYCLES(3)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .pll_locked_i(pll_locked_i),
    .btn_i(btn_i), .led_i(led_i), .core_reset_o(core_reset_o),
    .btn_level_o(btn_level_o), .btn_rise_o(btn_rise_o),
    .btn_fall_o(btn_fall_o), .led_o(led_o)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_i = 1'b1; pll_locked_i = 1'b0; btn_i = '0; led_i = '0;

    // Reset state
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("rst_core_reset", 32'(core_reset_o), 32'd1);
      chk("rst_level", 32'(btn_level_o), 32'd0);
      chk("rst_strobes", 32'({btn_rise_o, btn_fall_o}), 32'd0);
      chk("rst_led", 32'(led_o), 32'd0);
    end
    reset_i = 1'b0;
    tick();
    tick();

    // Lock rise: release on the 11th edge
    pll_locked_i = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk("release_core_reset", 32'(core_reset_o), (k < 11) ? 32'd1 : 32'd0);
      chk("release_others", 32'({btn_level_o, btn_rise_o, btn_fall_o, led_o}), 32'd0);
    end

    // Lock drop while running: reset returns on the third edge
    pll_locked_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("lockdrop_core_reset", 32'(core_reset_o), (k < 3) ? 32'd1 - 32'd1 : 32'd1);
    end

    // Lock glitch: 5 high, 1 low, then high; release 11 edges after 2nd rise
    for (int k = 1; k <= 19; k++) begin
      pll_locked_i = (k != 6);
      tick();
      chk("glitch_core_reset", 32'(core_reset_o), (k < 17) ? 32'd1 : 32'd0);
    end

    // Clean press and release on channel 0
    btn_i = 3'b001;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("press_level", 32'(btn_level_o), (k >= 6) ? 32'd1 : 32'd0);
      chk("press_rise", 32'(btn_rise_o), (k == 6) ? 32'd1 : 32'd0);
      chk("press_fall", 32'(btn_fall_o), 32'd0);
    end
    btn_i = 3'b000;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("release_level", 32'(btn_level_o), (k < 6) ? 32'd1 : 32'd0);
      chk("release_fall", 32'(btn_fall_o), (k == 6) ? 32'd1 : 32'd0);
      chk("release_rise", 32'(btn_rise_o), 32'd0);
    end

    // Bounce on channel 1: 1,1,1,0 then steady 1; only the final run counts
    rise_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      btn_i = (k != 4) ? 3'b010 : 3'b000;
      tick();
      if (btn_rise_o[1]) rise_cnt++;
      chk("bounce_level", 32'(btn_level_o), (k >= 10) ? 32'd2 : 32'd0);
      chk("bounce_rise", 32'(btn_rise_o), (k == 10) ? 32'd2 : 32'd0);
    end
    chk("bounce_rise_count", 32'(rise_cnt), 32'd1);
    btn_i = 3'b000;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("bounce_release_level", 32'(btn_level_o), (k < 6) ? 32'd2 : 32'd0);
      chk("bounce_release_fall", 32'(btn_fall_o), (k == 6) ? 32'd2 : 32'd0);
    end

    // LED stretch: single pulse on led 2
    for (int k = 1; k <= 6; k++) begin
      led_i = (k == 1) ? 4'b0100 : 4'b0000;
      tick();
      chk("stretch_single", 32'(led_o), (k <= 4) ? 32'h4 : 32'h0);
    end
    // Retrigger two cycles after the first pulse
    for (int k = 1; k <= 8; k++) begin
      led_i = (k == 1 || k == 3) ? 4'b0100 : 4'b0000;
      tick();
      chk("stretch_retrigger", 32'(led_o), (k <= 6) ? 32'h4 : 32'h0);
    end

    // Mid-operation reset while button 0 is pressed and LED 0 is stretching
    btn_i = 3'b001;
    for (int k = 1; k <= 6; k++) tick();
    chk("pre_reset_level", 32'(btn_level_o), 32'd1);
    chk("pre_reset_rise", 32'(btn_rise_o), 32'd1);
    led_i = 4'b0001;
    tick();
    led_i = 4'b0000;
    tick();
    chk("pre_reset_led", 32'(led_o), 32'd1);
    reset_i = 1'b1;
    tick();
    chk("midrst_led", 32'(led_o), 32'd0);
    chk("midrst_level", 32'(btn_level_o), 32'd0);
    chk("midrst_core_reset", 32'(core_reset_o), 32'd1);
    chk("midrst_strobes", 32'({btn_rise_o, btn_fall_o}), 32'd0);
    reset_i = 1'b0;

    // After reset: level re-accepted while core held in reset, strobe suppressed
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("postrst_level", 32'(btn_level_o), (k >= 6) ? 32'd1 : 32'd0);
      chk("postrst_rise", 32'(btn_rise_o), 32'd0);
      chk("postrst_core_reset", 32'(core_reset_o), (k < 11) ? 32'd1 : 32'd0);
      chk("postrst_led", 32'(led_o), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
